// File: rtl/seq_shifter_if.sv
// Request/response bundle for seq_shifter: operand, opcode and amount in; result and carry out.
// Both directions use valid/ready handshakes, and flush aborts the current operation.
interface seq_shifter_if #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned SHAMT_W = 5
);
   logic               in_valid;
   logic               in_ready;
   logic [2:0]         op;
   logic [SHAMT_W-1:0] amt;
   logic [WIDTH-1:0]   bin;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out;
   logic               carry;

   modport master (
      output in_valid, op, amt, bin, flush, out_ready,
      input  in_ready, out_valid, out, carry
   );

   modport slave (
      input  in_valid, op, amt, bin, flush, out_ready,
      output in_ready, out_valid, out, carry
   );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: shifts up to STEP bits per clock (LSL/LSR/ASR/ROL/ROR).
// Reports the last bit shifted out as carry, with valid/ready handshakes on both sides.
module seq_shifter #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned SHAMT_W = 5,
   parameter int unsigned STEP    = 1
) (
   input logic          clk,
   input logic          reset_n,
   seq_shifter_if.slave bus
);

   localparam logic [2:0] OpLsl = 3'b001;
   localparam logic [2:0] OpLsr = 3'b010;
   localparam logic [2:0] OpAsr = 3'b011;
   localparam logic [2:0] OpRol = 3'b100;
   localparam logic [2:0] OpRor = 3'b101;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               carry_q, carry_d;

   logic [31:0]        step_s;
   logic [WIDTH-1:0]   step_w;
   logic               step_c;

   function automatic logic is_pass(input logic [2:0] o);
      return (o == 3'b000) || (o[2:1] == 2'b11);
   endfunction

   // One clock's worth of work: min(STEP, count) single-bit steps chained combinationally.
   always_comb begin
      step_s = (32'(cnt_q) < STEP) ? 32'(cnt_q) : 32'(STEP);
      step_w = work_q;
      step_c = 1'b0;
      for (int unsigned i = 0; i < STEP; i++) begin
         if (i < step_s) begin
            case (op_q)
               OpLsl: begin
                  step_c = step_w[WIDTH-1];
                  step_w = {step_w[WIDTH-2:0], 1'b0};
               end
               OpLsr: begin
                  step_c = step_w[0];
                  step_w = {1'b0, step_w[WIDTH-1:1]};
               end
               OpAsr: begin
                  step_c = step_w[0];
                  step_w = {step_w[WIDTH-1], step_w[WIDTH-1:1]};
               end
               OpRol: begin
                  step_c = step_w[WIDTH-1];
                  step_w = {step_w[WIDTH-2:0], step_w[WIDTH-1]};
               end
               OpRor: begin
                  step_c = step_w[0];
                  step_w = {step_w[0], step_w[WIDTH-1:1]};
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      out_d   = out_q;
      carry_d = carry_q;

      if (bus.flush) begin
         // Abort without touching the presented result.
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  op_d   = bus.op;
                  cnt_d  = bus.amt;
                  work_d = bus.bin;
                  if (is_pass(bus.op) || (bus.amt == '0)) begin
                     out_d   = bus.bin;
                     carry_d = 1'b0;
                     state_d = StDone;
                  end else begin
                     state_d = StShift;
                  end
               end
            end
            StShift: begin
               work_d = step_w;
               cnt_d  = cnt_q - SHAMT_W'(step_s);
               if (32'(cnt_q) == step_s) begin
                  out_d   = step_w;
                  carry_d = step_c;
                  state_d = StDone;
               end
            end
            StDone: begin
               if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         op_q    <= '0;
         cnt_q   <= '0;
         work_q  <= '0;
         out_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         out_q   <= out_d;
         carry_q <= carry_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.out       = out_q;
   assign bus.carry     = carry_q;

endmodule
